// File: rtl/spi_slave_frame.sv
// Clock-oversampled SPI slave for all four CPOL/CPHA modes, with configurable frame width and bit order.
// It supports back-to-back frames under one SS, emits a one-cycle rx_valid per word and reports truncated frames.
module spi_slave_frame #(
  parameter int unsigned FRAME_W     = 16,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SCLK,
  input  logic               MOSI,
  input  logic               SS,
  output logic               MISO,
  output logic               miso_oe,
  input  logic [FRAME_W-1:0] tx_data,
  output logic               tx_ack,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               busy
);

  localparam int unsigned     CW       = $clog2(FRAME_W + 1);
  localparam logic            IDLE_LVL = (CPOL != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0]   LAST_CNT = CW'(FRAME_W - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_r;
  state_t state_n;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] ss_sync_r;
  logic [SYNC_STAGES-1:0] fill_r;

  logic sclk_last_s;
  logic mosi_last_s;
  logic ss_last_s;
  logic filled_s;
  logic sclk_prev_r;
  logic ss_prev_r;

  logic lead_s;
  logic trail_s;
  logic sample_s;
  logic shift_s;
  logic ss_fall_s;
  logic ss_rise_s;

  logic sample_p_r;
  logic shift_p_r;
  logic ss_fall_p_r;
  logic ss_rise_p_r;
  logic mosi_p_r;

  logic load_s;
  logic end_s;
  logic do_sample_s;
  logic do_shift_s;
  logic last_bit_s;

  logic [CW-1:0]      cnt_r;
  logic [FRAME_W-1:0] rx_sr_r;
  logic [FRAME_W-1:0] rx_word_s;
  logic [FRAME_W-1:0] tx_word_r;
  logic [FRAME_W-1:0] rx_data_r;
  logic               miso_r;
  logic               tx_ack_r;
  logic               done_r;
  logic               rx_valid_r;
  logic               frame_err_r;

  // Select the tx_word bit that belongs on MISO for bit position c.
  function automatic logic tx_bit(input logic [FRAME_W-1:0] word, input logic [CW-1:0] c);
    logic [FRAME_W-1:0] t;
    if (MSB_FIRST != 0) begin
      t      = word << c;
      tx_bit = t[FRAME_W-1];
    end else begin
      t      = word >> c;
      tx_bit = t[0];
    end
  endfunction

  // Input synchronisers; fill_r marks when the SS pipeline holds only real samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_r <= {SYNC_STAGES{IDLE_LVL}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      ss_sync_r   <= {SYNC_STAGES{1'b1}};
      fill_r      <= {SYNC_STAGES{1'b0}};
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], SS};
      fill_r      <= {fill_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sclk_last_s = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_last_s = mosi_sync_r[SYNC_STAGES-1];
  assign ss_last_s   = ss_sync_r[SYNC_STAGES-1];
  assign filled_s    = fill_r[SYNC_STAGES-1];

  // ss_prev_r only learns "high" from a real sample, so SS held low through reset never looks like a fall.
  assign lead_s    = (sclk_last_s != sclk_prev_r) && (sclk_last_s != IDLE_LVL);
  assign trail_s   = (sclk_last_s != sclk_prev_r) && (sclk_last_s == IDLE_LVL);
  assign sample_s  = (CPHA != 0) ? trail_s : lead_s;
  assign shift_s   = (CPHA != 0) ? lead_s : trail_s;
  assign ss_fall_s = ss_prev_r && !ss_last_s;
  assign ss_rise_s = filled_s && ss_last_s && !ss_prev_r;

  // Edge history and registered event pulses, with MOSI kept aligned to its sample pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_r <= IDLE_LVL;
      ss_prev_r   <= 1'b0;
      sample_p_r  <= 1'b0;
      shift_p_r   <= 1'b0;
      ss_fall_p_r <= 1'b0;
      ss_rise_p_r <= 1'b0;
      mosi_p_r    <= 1'b0;
    end else begin
      sclk_prev_r <= sclk_last_s;
      ss_prev_r   <= filled_s && ss_last_s;
      sample_p_r  <= sample_s;
      shift_p_r   <= shift_s;
      ss_fall_p_r <= ss_fall_s;
      ss_rise_p_r <= ss_rise_s;
      mosi_p_r    <= mosi_last_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state and per-cycle actions; an SS rise pre-empts a coincident SCLK event.
  always_comb begin
    state_n     = state_r;
    load_s      = 1'b0;
    end_s       = 1'b0;
    do_sample_s = 1'b0;
    do_shift_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (ss_fall_p_r) begin
          state_n = ACTIVE;
          load_s  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      ACTIVE: begin
        if (ss_rise_p_r) begin
          state_n = IDLE;
          end_s   = 1'b1;
        end else begin
          state_n     = ACTIVE;
          do_sample_s = sample_p_r;
          do_shift_s  = shift_p_r;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign last_bit_s = do_sample_s && (cnt_r == LAST_CNT);
  assign rx_word_s  = (MSB_FIRST != 0) ? {rx_sr_r[FRAME_W-2:0], mosi_p_r}
                                       : {mosi_p_r, rx_sr_r[FRAME_W-1:1]};

  // Shift registers, bit counter and output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= {CW{1'b0}};
      rx_sr_r     <= {FRAME_W{1'b0}};
      tx_word_r   <= {FRAME_W{1'b0}};
      rx_data_r   <= {FRAME_W{1'b0}};
      miso_r      <= 1'b0;
      tx_ack_r    <= 1'b0;
      done_r      <= 1'b0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      tx_ack_r    <= 1'b0;
      done_r      <= 1'b0;
      frame_err_r <= 1'b0;
      rx_valid_r  <= done_r;
      if (load_s) begin
        tx_word_r <= tx_data;
        tx_ack_r  <= 1'b1;
        cnt_r     <= {CW{1'b0}};
        miso_r    <= tx_bit(tx_data, {CW{1'b0}});
      end else if (end_s) begin
        frame_err_r <= (cnt_r != {CW{1'b0}});
        cnt_r       <= {CW{1'b0}};
      end else if (do_sample_s) begin
        rx_sr_r <= rx_word_s;
        if (last_bit_s) begin
          cnt_r     <= {CW{1'b0}};
          rx_data_r <= rx_word_s;
          done_r    <= 1'b1;
          tx_word_r <= tx_data;
          tx_ack_r  <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else if (do_shift_s) begin
        miso_r <= tx_bit(tx_word_r, cnt_r);
      end
    end
  end

  assign MISO      = miso_r;
  assign miso_oe   = (state_r == ACTIVE);
  assign busy      = (state_r == ACTIVE);
  assign tx_ack    = tx_ack_r;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench for spi_slave_frame: four CPOL/CPHA builds plus an LSB-first 10-bit build.
// Each instance has its own SS/SCLK, and a bit-banged master drives them one at a time.
module tb_spi_slave_frame;

  localparam int HALF = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mosi;
  logic [4:0]  sclk;
  logic [4:0]  ss;
  logic [15:0] tx16;
  logic [9:0]  tx10;

  wire [4:0]  miso, miso_oe, tx_ack, rx_valid, frame_err, busy;
  wire [15:0] rx16 [4];
  wire [9:0]  rx10;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_mode
      spi_slave_frame #(
        .FRAME_W(16), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1), .SYNC_STAGES(2)
      ) u_dut (
        .clk(clk), .rst(rst), .SCLK(sclk[g]), .MOSI(mosi), .SS(ss[g]),
        .MISO(miso[g]), .miso_oe(miso_oe[g]), .tx_data(tx16), .tx_ack(tx_ack[g]),
        .rx_data(rx16[g]), .rx_valid(rx_valid[g]), .frame_err(frame_err[g]), .busy(busy[g])
      );
    end
  endgenerate

  spi_slave_frame #(
    .FRAME_W(10), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)
  ) u_lsb (
    .clk(clk), .rst(rst), .SCLK(sclk[4]), .MOSI(mosi), .SS(ss[4]),
    .MISO(miso[4]), .miso_oe(miso_oe[4]), .tx_data(tx10), .tx_ack(tx_ack[4]),
    .rx_data(rx10), .rx_valid(rx_valid[4]), .frame_err(frame_err[4]), .busy(busy[4])
  );

  int          cyc = 0;
  int          last_samp = 0;
  int          rxv_cnt [5];
  int          ack_cnt [5];
  int          err_cnt [5];
  int          rxv_cyc [5];
  logic [15:0] rx_last [5];
  logic [15:0] rx_prev [5];
  int          vectors = 0;
  int          miscompares = 0;

  // Pulse monitor: counts strobes and records each word delivered with rx_valid.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (rx_valid[k]) begin
        rxv_cnt[k]++;
        rxv_cyc[k] = cyc;
        rx_prev[k] = rx_last[k];
        rx_last[k] = (k < 4) ? rx16[k] : {6'd0, rx10};
      end
      if (tx_ack[k])    ack_cnt[k]++;
      if (frame_err[k]) err_cnt[k]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  // Bit-bang nbits of one frame on instance d; returns what the master sampled on MISO.
  task automatic frame(input logic [2:0] d, input int nbits, input int w, input bit msb,
                       input logic [31:0] out_w, output logic [31:0] in_w);
    logic       cpol, cpha;
    logic [4:0] idx;
    cpol = d[1] & ~d[2];
    cpha = d[0] & ~d[2];
    in_w = 32'd0;
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? 5'(w - 1 - i) : 5'(i);
      if (!cpha) begin
        mosi = out_w[idx];
        half();
        sclk[d] = ~cpol;
        last_samp = cyc + 1;
        in_w[idx] = miso[d];
        half();
        sclk[d] = cpol;
      end else begin
        half();
        sclk[d] = ~cpol;
        mosi = out_w[idx];
        half();
        sclk[d] = cpol;
        last_samp = cyc + 1;
        in_w[idx] = miso[d];
      end
    end
  endtask

  task automatic ss_low(input logic [2:0] d);
    ss[d] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic ss_high(input logic [2:0] d);
    half();
    ss[d] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  logic [31:0] got1, got2;
  int          b_rxv, b_ack, b_err;

  initial begin
    rst  = 1'b1;
    mosi = 1'b0;
    ss   = 5'b11111;
    sclk = 5'b01100;
    tx16 = 16'h1234;
    tx10 = 10'h1A7;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_oe", 32'(miso_oe), 32'd0);
    chk("rst_ack", 32'(tx_ack), 32'd0);
    chk("rst_rxv", 32'(rx_valid), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx0", 32'(rx16[0]), 32'd0);
    chk("rst_rx10", 32'(rx10), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // MOSI activity with SS high and SCLK idle must not start anything
    for (int i = 0; i < 20; i++) begin
      mosi = ~mosi;
      @(negedge clk);
    end
    chk("idle_rxv", 32'(rxv_cnt[0] + rxv_cnt[1] + rxv_cnt[2] + rxv_cnt[3] + rxv_cnt[4]), 32'd0);
    chk("idle_ack", 32'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3] + ack_cnt[4]), 32'd0);
    chk("idle_oe", 32'(miso_oe), 32'd0);

    // Mode 0 basic frame and latency
    tx16 = 16'h1234;
    ss_low(3'd0);
    chk("t1_ack_fall", 32'(ack_cnt[0]), 32'd1);
    chk("t1_busy", 32'(busy[0]), 32'd1);
    chk("t1_oe", 32'(miso_oe[0]), 32'd1);
    frame(3'd0, 16, 16, 1'b1, 32'h0000A53C, got1);
    ss_high(3'd0);
    chk("t1_rxv_cnt", 32'(rxv_cnt[0]), 32'd1);
    chk("t1_rx_word", 32'(rx_last[0]), 32'h0000A53C);
    chk("t1_rx_data", 32'(rx16[0]), 32'h0000A53C);
    chk("t1_miso_word", got1, 32'h00001234);
    chk("t1_latency", 32'(rxv_cyc[0] - last_samp), 32'd4);
    chk("t1_ack_total", 32'(ack_cnt[0]), 32'd2);
    chk("t1_err", 32'(err_cnt[0]), 32'd0);
    chk("t1_oe_off", 32'(miso_oe[0]), 32'd0);

    // Back-to-back frames in every CPOL/CPHA mode
    for (int m = 0; m < 4; m++) begin
      b_rxv = rxv_cnt[m];
      b_ack = ack_cnt[m];
      b_err = err_cnt[m];
      tx16  = 16'h1234;
      ss_low(3'(m));
      chk("t2_ack_fall", 32'(ack_cnt[m] - b_ack), 32'd1);
      tx16 = 16'hBEEF;
      frame(3'(m), 16, 16, 1'b1, 32'h00008001, got1);
      frame(3'(m), 16, 16, 1'b1, 32'h00007FFE, got2);
      ss_high(3'(m));
      chk("t2_rxv_cnt", 32'(rxv_cnt[m] - b_rxv), 32'd2);
      chk("t2_rx_first", 32'(rx_prev[m]), 32'h00008001);
      chk("t2_rx_second", 32'(rx_last[m]), 32'h00007FFE);
      chk("t2_rx_data", 32'(rx16[m]), 32'h00007FFE);
      chk("t2_miso_first", got1, 32'h00001234);
      chk("t2_miso_second", got2, 32'h0000BEEF);
      chk("t2_ack_total", 32'(ack_cnt[m] - b_ack), 32'd3);
      chk("t2_err", 32'(err_cnt[m] - b_err), 32'd0);
    end

    // LSB-first, 10-bit frame
    tx10 = 10'h1A7;
    ss_low(3'd4);
    frame(3'd4, 10, 10, 1'b0, 32'h000002B5, got1);
    ss_high(3'd4);
    chk("t3_rxv_cnt", 32'(rxv_cnt[4]), 32'd1);
    chk("t3_rx_data", 32'(rx10), 32'h000002B5);
    chk("t3_miso_word", got1, 32'h000001A7);

    // Truncated frame: 7 of 16 bits
    b_rxv = rxv_cnt[0];
    b_err = err_cnt[0];
    ss_low(3'd0);
    frame(3'd0, 7, 16, 1'b1, 32'h0000FFFF, got1);
    ss_high(3'd0);
    chk("t4_err", 32'(err_cnt[0] - b_err), 32'd1);
    chk("t4_no_rxv", 32'(rxv_cnt[0] - b_rxv), 32'd0);
    chk("t4_rx_held", 32'(rx16[0]), 32'h00007FFE);
    chk("t4_oe", 32'(miso_oe[0]), 32'd0);
    chk("t4_busy", 32'(busy[0]), 32'd0);

    // Reset mid-frame with SS held low
    b_rxv = rxv_cnt[0];
    b_err = err_cnt[0];
    ss_low(3'd0);
    frame(3'd0, 9, 16, 1'b1, 32'h00000F0F, got1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_miso", 32'(miso[0]), 32'd0);
    chk("t5_oe", 32'(miso_oe[0]), 32'd0);
    chk("t5_ack", 32'(tx_ack[0]), 32'd0);
    chk("t5_rx_data", 32'(rx16[0]), 32'd0);
    chk("t5_rxv", 32'(rx_valid[0]), 32'd0);
    chk("t5_err", 32'(frame_err[0]), 32'd0);
    chk("t5_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    b_ack = ack_cnt[0];
    repeat (4) @(negedge clk);
    frame(3'd0, 7, 16, 1'b1, 32'h0000F0F0, got1);
    repeat (8) @(negedge clk);
    chk("t5_ignored_busy", 32'(busy[0]), 32'd0);
    chk("t5_ignored_ack", 32'(ack_cnt[0] - b_ack), 32'd0);
    chk("t5_ignored_rxv", 32'(rxv_cnt[0] - b_rxv), 32'd0);
    chk("t5_ignored_err", 32'(err_cnt[0] - b_err), 32'd0);
    ss[0] = 1'b1;
    repeat (8) @(negedge clk);
    tx16 = 16'hC001;
    ss_low(3'd0);
    chk("t5_rejoin_ack", 32'(ack_cnt[0] - b_ack), 32'd1);
    frame(3'd0, 16, 16, 1'b1, 32'h00005AC3, got1);
    ss_high(3'd0);
    chk("t5_rx_data2", 32'(rx16[0]), 32'h00005AC3);
    chk("t5_rxv2", 32'(rxv_cnt[0] - b_rxv), 32'd1);
    chk("t5_miso_word", got1, 32'h0000C001);
    chk("t5_err2", 32'(err_cnt[0] - b_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
